// File: rtl/io_stream_fifo_pkg.sv
// Shared I/O buffering constants: FIFO read-mode selectors and the default
// word width/depth used for the cpu input and output streams.
package io_stream_fifo_pkg;
  localparam int FWFT_OFF      = 0;
  localparam int FWFT_ON       = 1;
  localparam int IO_DATA_WIDTH = 16;
  localparam int IO_DEPTH      = 8;
endpackage

// File: rtl/io_stream_fifo_ram.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module io_stream_fifo_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(DEPTH)-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0]     raddr,
  output logic [DATA_WIDTH-1:0]        rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/io_stream_fifo.sv
// Synchronous I/O stream FIFO with occupancy flags, sticky overflow/underflow
// errors and a registered or first-word-fall-through read side.
module io_stream_fifo
  import io_stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = IO_DATA_WIDTH,
  parameter int DEPTH      = IO_DEPTH,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = FWFT_OFF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      rd_en,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic                      underflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("io_stream_fifo: DEPTH must be a power of 2 and >= 2");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("io_stream_fifo: AF_LEVEL exceeds DEPTH");
  end
  if (AE_LEVEL >= DEPTH) begin : g_bad_ae
    $error("io_stream_fifo: AE_LEVEL must be below DEPTH");
  end

  logic [PTR_W:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count_q;
  logic                    overflow_q, underflow_q;
  logic [DATA_WIDTH-1:0]   ram_rdata;
  logic [DATA_WIDTH-1:0]   rd_data_p1;
  logic                    vld_p1;
  logic                    push, pop;

  io_stream_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[PTR_W-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[PTR_W-1:0]),
    .rdata (ram_rdata)
  );

  // Flags come only from registered pointers/count, never from wr_en/rd_en.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign pop  = rd_en & ~empty & ~clr;
  assign push = wr_en & (~full | pop) & ~clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      vld_p1      <= 1'b0;
      rd_data_p1  <= '0;
    end else if (clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      count_q     <= count_q + CNT_W'(push) - CNT_W'(pop);
      overflow_q  <= overflow_q | (wr_en & ~push);
      underflow_q <= underflow_q | (rd_en & ~pop);
      // Output register stage: word leaves storage on the popping edge.
      vld_p1 <= pop;
      if (pop) rd_data_p1 <= ram_rdata;
    end
  end

  assign rd_data  = (FWFT != FWFT_OFF) ? ram_rdata : rd_data_p1;
  assign rd_valid = (FWFT != FWFT_OFF) ? ~empty    : vld_p1;
endmodule

// File: tb/tb_io_stream_fifo.sv
// Directed bench for io_stream_fifo: a registered-read instance and a
// first-word-fall-through instance share clock and reset.
`timescale 1ns/1ps
module tb_io_stream_fifo;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        clr0 = 0, wr0 = 0, rd0 = 0;
  logic [15:0] wd0 = '0;
  logic [15:0] rdata0;
  logic        rvalid0, full0, empty0, af0, ae0, ov0, uf0;
  logic [3:0]  cnt0;

  logic        clr1 = 0, wr1 = 0, rd1 = 0;
  logic [15:0] wd1 = '0;
  logic [15:0] rdata1;
  logic        rvalid1, full1, empty1, af1, ae1, ov1, uf1;
  logic [3:0]  cnt1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  io_stream_fifo #(.DATA_WIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr0), .wr_en(wr0), .wr_data(wd0), .rd_en(rd0),
    .rd_data(rdata0), .rd_valid(rvalid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0), .overflow(ov0), .underflow(uf0));

  io_stream_fifo #(.DATA_WIDTH(16), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr1), .wr_en(wr1), .wr_data(wd1), .rd_en(rd1),
    .rd_data(rdata1), .rd_valid(rvalid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1), .overflow(ov1), .underflow(uf1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #7 rst_n = 1'b1;
    #1;
    total++;
    if ({empty0, ae0, cnt0, rvalid0, full0, af0, ov0, uf0, rdata0} !== {1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0})
      $display("FAIL reset0: got e=%b ae=%b cnt=%0d v=%b f=%b af=%b ov=%b uf=%b d=%h, want 1 1 0 0 0 0 0 0 0000",
               empty0, ae0, cnt0, rvalid0, full0, af0, ov0, uf0, rdata0);
    else passed++;
    total++;
    if ({empty1, ae1, cnt1, rvalid1, full1, af1, ov1, uf1} !== {1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset1: got e=%b ae=%b cnt=%0d v=%b f=%b af=%b ov=%b uf=%b, want 1 1 0 0 0 0 0 0",
               empty1, ae1, cnt1, rvalid1, full1, af1, ov1, uf1);
    else passed++;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      wr0 = 1; wd0 = 16'(i);
      tick();
      total++;
      if (cnt0 !== 4'(i) || af0 !== (i >= 6) || ae0 !== (i <= 2) || empty0 !== 1'b0)
        $display("FAIL fill_%0d: cnt=%0d af=%b ae=%b e=%b, want cnt=%0d af=%b ae=%b e=0",
                 i, cnt0, af0, ae0, empty0, i, (i >= 6), (i <= 2));
      else passed++;
    end
    wr0 = 0;
    total++;
    if (full0 !== 1'b1 || ov0 !== 1'b0) $display("FAIL full_flag: full=%b ov=%b, want 1 0", full0, ov0);
    else passed++;
    for (int i = 1; i <= 8; i++) begin
      rd0 = 1;
      tick();
      total++;
      if (rdata0 !== 16'(i) || rvalid0 !== 1'b1 || cnt0 !== 4'(8 - i))
        $display("FAIL drain_%0d: d=%h v=%b cnt=%0d, want d=%h v=1 cnt=%0d", i, rdata0, rvalid0, cnt0, 16'(i), 8 - i);
      else passed++;
    end
    rd0 = 0;
    total++;
    if (empty0 !== 1'b1 || full0 !== 1'b0) $display("FAIL drained_empty: e=%b f=%b, want 1 0", empty0, full0);
    else passed++;
    tick();
    total++;
    if (rvalid0 !== 1'b0 || rdata0 !== 16'h0008 || uf0 !== 1'b0)
      $display("FAIL valid_one_cycle: v=%b d=%h uf=%b, want 0 0008 0", rvalid0, rdata0, uf0);
    else passed++;
  endtask

  task automatic test_overflow_underflow();
    for (int i = 1; i <= 8; i++) begin
      wr0 = 1; wd0 = 16'(i); tick();
    end
    wd0 = 16'h00AA; tick();
    wr0 = 0;
    total++;
    if (ov0 !== 1'b1 || cnt0 !== 4'd8 || full0 !== 1'b1)
      $display("FAIL overflow: ov=%b cnt=%0d full=%b, want 1 8 1", ov0, cnt0, full0);
    else passed++;
    for (int i = 1; i <= 8; i++) begin
      rd0 = 1; tick();
      total++;
      if (rdata0 !== 16'(i)) $display("FAIL ovf_drain_%0d: d=%h, want %h", i, rdata0, 16'(i));
      else passed++;
    end
    tick();
    rd0 = 0;
    total++;
    if (uf0 !== 1'b1 || cnt0 !== 4'd0 || rvalid0 !== 1'b0 || ov0 !== 1'b1)
      $display("FAIL underflow: uf=%b cnt=%0d v=%b ov=%b, want 1 0 0 1", uf0, cnt0, rvalid0, ov0);
    else passed++;
    clr0 = 1; tick(); clr0 = 0;
    total++;
    if (ov0 !== 1'b0 || uf0 !== 1'b0 || cnt0 !== 4'd0 || empty0 !== 1'b1)
      $display("FAIL clr_flags: ov=%b uf=%b cnt=%0d e=%b, want 0 0 0 1", ov0, uf0, cnt0, empty0);
    else passed++;
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 8; i++) begin
      wr0 = 1; wd0 = 16'h0010 + 16'(i); tick();
    end
    wr0 = 1; rd0 = 1; wd0 = 16'h1234; tick();
    wr0 = 0; rd0 = 0;
    total++;
    if (cnt0 !== 4'd8 || ov0 !== 1'b0 || full0 !== 1'b1 || rdata0 !== 16'h0010 || rvalid0 !== 1'b1)
      $display("FAIL full_both: cnt=%0d ov=%b f=%b d=%h v=%b, want 8 0 1 0010 1", cnt0, ov0, full0, rdata0, rvalid0);
    else passed++;
    for (int i = 1; i <= 8; i++) begin
      logic [15:0] exp_d;
      exp_d = (i == 8) ? 16'h1234 : 16'h0010 + 16'(i);
      rd0 = 1; tick();
      total++;
      if (rdata0 !== exp_d) $display("FAIL sim_drain_%0d: d=%h, want %h", i, rdata0, exp_d);
      else passed++;
    end
    rd0 = 0;
    wr0 = 1; rd0 = 1; wd0 = 16'h0055; tick();
    wr0 = 0; rd0 = 0;
    total++;
    if (cnt0 !== 4'd1 || uf0 !== 1'b1 || rvalid0 !== 1'b0 || empty0 !== 1'b0)
      $display("FAIL empty_both: cnt=%0d uf=%b v=%b e=%b, want 1 1 0 0", cnt0, uf0, rvalid0, empty0);
    else passed++;
    clr0 = 1; wr0 = 1; tick(); clr0 = 0; wr0 = 0;
    total++;
    if (cnt0 !== 4'd0 || uf0 !== 1'b0 || empty0 !== 1'b1)
      $display("FAIL clr_priority: cnt=%0d uf=%b e=%b, want 0 0 1", cnt0, uf0, empty0);
    else passed++;
  endtask

  task automatic test_wrap();
    int bad = 0;
    wr0 = 1; wd0 = 16'h0009; tick();
    for (int i = 1; i < 20; i++) begin
      wr0 = 1; rd0 = 1; wd0 = 16'h0009 + 16'(i); tick();
      if (rdata0 !== 16'h0009 + 16'(i - 1) || cnt0 !== 4'd1 || rvalid0 !== 1'b1) begin
        if (bad == 0)
          $display("FAIL wrap_%0d: d=%h cnt=%0d v=%b, want d=%h cnt=1 v=1", i, rdata0, cnt0, rvalid0, 16'h0009 + 16'(i - 1));
        bad++;
      end
    end
    wr0 = 0; rd0 = 1; tick(); rd0 = 0;
    total++;
    if (bad != 0) $display("FAIL wrap_order: %0d bad pairs, want 0", bad);
    else passed++;
    total++;
    if (rdata0 !== 16'h001C || empty0 !== 1'b1 || uf0 !== 1'b0 || ov0 !== 1'b0)
      $display("FAIL wrap_last: d=%h e=%b uf=%b ov=%b, want 001c 1 0 0", rdata0, empty0, uf0, ov0);
    else passed++;
  endtask

  task automatic test_fwft();
    wr1 = 1; wd1 = 16'h0009; tick(); wr1 = 0;
    total++;
    if (rvalid1 !== 1'b1 || rdata1 !== 16'h0009) $display("FAIL fwft_present: v=%b d=%h, want 1 0009", rvalid1, rdata1);
    else passed++;
    wr1 = 1; wd1 = 16'h000A; tick(); wr1 = 0;
    total++;
    if (rvalid1 !== 1'b1 || rdata1 !== 16'h0009 || cnt1 !== 4'd2)
      $display("FAIL fwft_hold: v=%b d=%h cnt=%0d, want 1 0009 2", rvalid1, rdata1, cnt1);
    else passed++;
    rd1 = 1; tick(); rd1 = 0;
    total++;
    if (rvalid1 !== 1'b1 || rdata1 !== 16'h000A || cnt1 !== 4'd1)
      $display("FAIL fwft_next: v=%b d=%h cnt=%0d, want 1 000a 1", rvalid1, rdata1, cnt1);
    else passed++;
    rd1 = 1; tick(); rd1 = 0;
    total++;
    if (rvalid1 !== 1'b0 || empty1 !== 1'b1 || uf1 !== 1'b0)
      $display("FAIL fwft_consume: v=%b e=%b uf=%b, want 0 1 0", rvalid1, empty1, uf1);
    else passed++;
  endtask

  task automatic test_async_reset();
    wr0 = 1; wd0 = 16'h0077; tick(); tick();
    wr0 = 0; rd0 = 1; tick(); rd0 = 0;
    wr1 = 1; wd1 = 16'h0042; tick(); wr1 = 0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (cnt0 !== 4'd0 || empty0 !== 1'b1 || rvalid0 !== 1'b0 || rdata0 !== 16'h0 || rvalid1 !== 1'b0 || cnt1 !== 4'd0)
      $display("FAIL async_reset: cnt0=%0d e0=%b v0=%b d0=%h v1=%b cnt1=%0d, want 0 1 0 0000 0 0",
               cnt0, empty0, rvalid0, rdata0, rvalid1, cnt1);
    else passed++;
    tick();
    rst_n = 1'b1;
    tick();
    total++;
    if (empty0 !== 1'b1 || ae0 !== 1'b1 || empty1 !== 1'b1) $display("FAIL post_reset: e0=%b ae0=%b e1=%b, want 1 1 1", empty0, ae0, empty1);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow_underflow();
    test_simultaneous();
    test_wrap();
    test_fwft();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
